// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - coupled logistic/tent key word generator with synchronous-read M/N buffers
module key_expansion_seq #(
    parameter int W       = 32,
    parameter int LEN     = 256,
    parameter int DISCARD = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [W-1:0]            m,
    input  logic [W-1:0]            n,
    input  logic [W-1:0]            r1,
    input  logic [W-1:0]            r2,
    input  logic [$clog2(LEN)-1:0]  rd_addr,
    output logic [W-1:0]            m_rd,
    output logic [W-1:0]            n_rd,
    output logic                    busy,
    output logic                    done,
    output logic                    valid
);
    localparam int AW = $clog2(LEN);
    localparam int DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;
    localparam int CW = (AW > DW) ? AW : DW;
    localparam logic [CW-1:0] BURN_LAST = CW'((DISCARD > 0) ? DISCARD - 1 : 0);
    localparam logic [CW-1:0] FILL_LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {IDLE, BURN, FILL, DONE} state_t;

    function automatic logic [W-1:0] sat(input logic [2*W-1:0] v);
        return (|v[2*W-1:W]) ? {W{1'b1}} : v[W-1:0];
    endfunction

    function automatic logic [W-1:0] logistic(input logic [W-1:0] r, input logic [W-1:0] x);
        logic [W-1:0]   nx;
        logic [W-1:0]   h;
        logic [2*W-1:0] p;
        logic [2*W-1:0] q;
        nx = ~x;
        p  = {{W{1'b0}}, x} * {{W{1'b0}}, nx};
        h  = p[2*W-1:W];
        q  = {{W{1'b0}}, r} * {{W{1'b0}}, h};
        return sat(q >> (W - 2));
    endfunction

    function automatic logic [W-1:0] tent(input logic [W-1:0] r, input logic [W-1:0] x);
        logic [W-1:0]   y;
        logic [2*W-1:0] q;
        y = x[W-1] ? ~x : x;
        q = {{W{1'b0}}, r} * {{W{1'b0}}, y};
        return sat(q >> (W - 3));
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   xm_q, xm_d, xn_q, xn_d;
    logic [W-1:0]   r1_q, r1_d, r2_q, r2_d;
    logic           busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [W-1:0]   m_rd_q, n_rd_q;
    logic [W-1:0]   xm_step, xn_step;
    logic           wr_en;

    logic [W-1:0]   buf_m [0:LEN-1];
    logic [W-1:0]   buf_n [0:LEN-1];

    // The two channels swap which parameter drives the logistic and tent terms.
    always_comb begin
        xm_step = logistic(r1_q, xm_q) + tent(r2_q, xm_q);
        xn_step = logistic(r2_q, xn_q) + tent(r1_q, xn_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xm_d    = xm_q;
        xn_d    = xn_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    r1_d    = r1;
                    r2_d    = r2;
                    xm_d    = m;
                    xn_d    = n;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (DISCARD > 0) ? BURN : FILL;
                end
            end
            BURN: begin
                xm_d = xm_step;
                xn_d = xn_step;
                if (cnt_q == BURN_LAST) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FILL: begin
                wr_en = 1'b1;
                xm_d  = xm_step;
                xn_d  = xn_step;
                if (cnt_q == FILL_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xm_q    <= '0;
            xn_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            m_rd_q  <= '0;
            n_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xm_q    <= xm_d;
            xn_q    <= xn_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            m_rd_q  <= buf_m[rd_addr];
            n_rd_q  <= buf_n[rd_addr];
        end
    end

    // Buffers survive reset; a reset edge only suppresses the pending write.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            buf_m[cnt_q[AW-1:0]] <= xm_q;
            buf_n[cnt_q[AW-1:0]] <= xn_q;
        end
    end

    assign m_rd  = m_rd_q;
    assign n_rd  = n_rd_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb/tb_key_expansion_seq.sv - scoreboard bench for key_expansion_seq (small and full-size instances)
module tb_key_expansion_seq;
    localparam int AW_ = 16, AL = 8,   AD = 0;
    localparam int BW_ = 32, BL = 256, BD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [31:0] sm, sn, sr1, sr2;
    logic [7:0]  rd_addr;
    logic        rd_req;
    int          rd_sel;
    logic [15:0] m_rd_a, n_rd_a;
    logic [31:0] m_rd_b, n_rd_b;
    logic        busy_a, done_a, valid_a, busy_b, done_b, valid_b;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_m[$];
    logic [31:0] sb_n[$];
    logic        pend_q = 1'b0;
    int          pend_sel_q = 0;

    logic [31:0] model_m [2][256];
    logic [31:0] model_n [2][256];
    logic [31:0] new_m [256];
    logic [31:0] new_n [256];
    int          have_prev [2] = '{0, 0};

    always #5 clk = ~clk;

    key_expansion_seq #(.W(AW_), .LEN(AL), .DISCARD(AD)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .m(sm[15:0]), .n(sn[15:0]), .r1(sr1[15:0]), .r2(sr2[15:0]),
        .rd_addr(rd_addr[2:0]), .m_rd(m_rd_a), .n_rd(n_rd_a),
        .busy(busy_a), .done(done_a), .valid(valid_a)
    );

    key_expansion_seq #(.W(BW_), .LEN(BL), .DISCARD(BD)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .m(sm), .n(sn), .r1(sr1), .r2(sr2),
        .rd_addr(rd_addr), .m_rd(m_rd_b), .n_rd(n_rd_b),
        .busy(busy_b), .done(done_b), .valid(valid_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: x is a fraction of 2^w; logistic r*x*(1-x) scaled by 4, tent slope r*8.
    function automatic logic [63:0] model_step(input int w, input logic [63:0] ra,
                                               input logic [63:0] rb, input logic [63:0] x);
        logic [63:0] mask, nx, h, lq, y, tq;
        mask = (64'd1 << w) - 64'd1;
        nx   = mask - x;
        h    = (x * nx) >> w;
        lq   = (ra * h) >> (w - 2);
        if (lq > mask) lq = mask;
        y    = (x < (64'd1 << (w - 1))) ? x : nx;
        tq   = (rb * y) >> (w - 3);
        if (tq > mask) tq = mask;
        return (lq + tq) & mask;
    endfunction

    function automatic logic get_busy(input int s);  return s ? busy_b  : busy_a;  endfunction
    function automatic logic get_done(input int s);  return s ? done_b  : done_a;  endfunction
    function automatic logic get_valid(input int s); return s ? valid_b : valid_a; endfunction

    task automatic set_start(input int s, input logic v);
        if (s != 0) start_b = v; else start_a = v;
    endtask

    // Monitor: a read sampled at a rising edge is compared at the following falling edge.
    always @(posedge clk) begin
        pend_q     <= rd_req;
        pend_sel_q <= rd_sel;
    end

    always @(negedge clk) begin
        if (pend_q) begin
            if (sb_m.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: got read data with no expected entry, expected entry present");
            end else begin
                logic [31:0] em, en;
                em = sb_m.pop_front();
                en = sb_n.pop_front();
                check("m_rd", pend_sel_q ? m_rd_b : {16'h0, m_rd_a}, em);
                check("n_rd", pend_sel_q ? n_rd_b : {16'h0, n_rd_a}, en);
            end
        end
    end

    task automatic build_expected(input int s, input logic [31:0] m, input logic [31:0] n,
                                  input logic [31:0] r1, input logic [31:0] r2);
        int w, len, d;
        logic [63:0] mask, xm, xn, a1, a2;
        w    = s ? BW_ : AW_;
        len  = s ? BL : AL;
        d    = s ? BD : AD;
        mask = (64'd1 << w) - 64'd1;
        xm   = {32'h0, m} & mask;
        xn   = {32'h0, n} & mask;
        a1   = {32'h0, r1} & mask;
        a2   = {32'h0, r2} & mask;
        for (int i = 0; i < d; i++) begin
            xm = model_step(w, a1, a2, xm);
            xn = model_step(w, a2, a1, xn);
        end
        for (int i = 0; i < len; i++) begin
            new_m[i] = xm[31:0];
            new_n[i] = xn[31:0];
            xm = model_step(w, a1, a2, xm);
            xn = model_step(w, a2, a1, xn);
        end
    endtask

    task automatic readout(input int s);
        int len;
        len = s ? BL : AL;
        for (int a = 0; a < len; a++) begin
            rd_addr = 8'(a);
            rd_sel  = s;
            rd_req  = 1'b1;
            sb_m.push_back(model_m[s][a]);
            sb_n.push_back(model_n[s][a]);
            @(negedge clk);
        end
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_gen(input int s, input logic [31:0] m, input logic [31:0] n,
                           input logic [31:0] r1, input logic [31:0] r2);
        int len, d, busy_n, done_n, done_at;
        len = s ? BL : AL;
        d   = s ? BD : AD;
        build_expected(s, m, n, r1, r2);
        @(negedge clk);
        sm = m; sn = n; sr1 = r1; sr2 = r2;
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        sm = $urandom; sn = $urandom; sr1 = $urandom; sr2 = $urandom;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c < d + len + 4; c++) begin
            if (c > 0) @(negedge clk);
            if (get_busy(s)) busy_n++;
            if (get_done(s)) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (c == 1) check("valid_cleared_at_start", {31'h0, get_valid(s)}, 32'h0);
            set_start(s, (c == 2) || (c == d + len));
            rd_req = (c == 0) && (have_prev[s] != 0);
            if (rd_req) begin
                rd_sel  = s;
                rd_addr = 8'(len - 1);
                sb_m.push_back(model_m[s][len-1]);
                sb_n.push_back(model_n[s][len-1]);
            end
        end
        set_start(s, 1'b0);
        rd_req = 1'b0;
        check("busy_cycles", busy_n, d + len);
        check("done_cycle", done_at, d + len + 1);
        check("done_pulses", done_n, 1);
        check("valid_after_done", {31'h0, get_valid(s)}, 32'h1);
        for (int i = 0; i < len; i++) begin
            model_m[s][i] = new_m[i];
            model_n[s][i] = new_n[i];
        end
        have_prev[s] = 1;
        readout(s);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; rd_req = 1'b0; rd_sel = 0;
        rd_addr = '0; sm = '0; sn = '0; sr1 = '0; sr2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy_a", {31'h0, busy_a}, 0);
        check("rst_done_a", {31'h0, done_a}, 0);
        check("rst_valid_a", {31'h0, valid_a}, 0);
        check("rst_mrd_a", {16'h0, m_rd_a}, 0);
        check("rst_nrd_a", {16'h0, n_rd_a}, 0);
        check("rst_busy_b", {31'h0, busy_b}, 0);
        check("rst_valid_b", {31'h0, valid_b}, 0);
        check("rst_mrd_b", m_rd_b, 0);
        rst = 1'b0;

        run_gen(0, 32'h1234, $urandom, 32'h0, 32'h0);
        check("a_word0_seed", model_m[0][0], 32'h1234);
        run_gen(0, 32'h1000, $urandom, 32'h0, 32'h2000);
        run_gen(0, 32'h0, 32'h0, 32'hFFFF, 32'hFFFF);
        for (int i = 0; i < 3; i++) run_gen(0, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 2; i++) run_gen(1, $urandom, $urandom, $urandom, $urandom);

        // Abort dut_a at FILL cnt=3.
        @(negedge clk);
        sm = $urandom; sn = $urandom; sr1 = $urandom; sr2 = $urandom;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", {31'h0, busy_a}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'h0, busy_a}, 0);
        check("abort_valid", {31'h0, valid_a}, 0);
        check("abort_done", {31'h0, done_a}, 0);
        check("abort_valid_b", {31'h0, valid_b}, 0);
        check("abort_mrd_b", m_rd_b, 0);
        readout(1);

        // Reset and start on the same edge: reset wins.
        rst = 1'b1; start_a = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0;
        @(negedge clk);
        check("rst_start_busy", {31'h0, busy_a}, 0);

        run_gen(0, $urandom, $urandom, $urandom, $urandom);
        check("sb_drained", sb_m.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_expansion_seq.md
KEY_EXPANSION_SEQ -- requirements
Module: key_expansion_seq

Interface
REQ-001 Parameter W, default 32, meaning word width of seeds, control parameters and key words; SHALL be at least 8.
REQ-002 Parameter LEN, default 256, meaning words generated per channel; SHALL be at least 2.
REQ-003 Parameter DISCARD, default 16, meaning burn-in iterations dropped before storage; SHALL be at least 0.
REQ-004 Port clk, input, 1 bit, meaning the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1 bit, meaning the reset; it SHALL be synchronous and active-high.
REQ-006 Port start, input, 1 bit, meaning a request to begin generation.
REQ-007 Port m, input, W bits, meaning the M-channel seed; port n, input, W bits, meaning the N-channel seed.
REQ-008 Port r1, input, W bits, meaning control parameter 1; port r2, input, W bits, meaning control parameter 2; both use Q2.(W-2) format.
REQ-009 Port rd_addr, input, clog2(LEN) bits, meaning the buffer read address.
REQ-010 Port m_rd, output, W bits, meaning the M word read out; port n_rd, output, W bits, meaning the N word read out.
REQ-011 Port busy, output, 1 bit, meaning generation is in progress; port done, output, 1 bit, meaning a one-cycle completion pulse; port valid, output, 1 bit, meaning both buffers hold a complete key set.

Function
REQ-012 Word x SHALL represent x/2^W; ~x denotes 2^W-1-x.
REQ-013 Logistic term L(r,x) SHALL be computed as: h = (x*~x) >> W; q = (r*h) >> (W-2); q saturated to 2^W-1.
REQ-014 Tent term T(r,x) SHALL be computed as: y = x when x < 2^(W-1), else ~x; q = (r*y) >> (W-3); q saturated to 2^W-1.
REQ-015 All products SHALL be full 2W-bit unsigned.
REQ-016 The M-channel step SHALL be FM(x) = (L(r1,x) + T(r2,x)) mod 2^W.
REQ-017 The N-channel step SHALL be FN(x) = (L(r2,x) + T(r1,x)) mod 2^W.
REQ-018 Each channel SHALL compute one step per cycle, and both channels SHALL run in lockstep.
REQ-019 The FSM SHALL have four states, IDLE, BURN, FILL and DONE, with a single counter cnt.
REQ-020 In IDLE with start=1, the block SHALL latch m, n, r1 and r2, set xm=m, xn=n, cnt=0 and valid=0, then go to BURN if DISCARD>0, else to FILL.
REQ-021 In BURN, the block SHALL set xm=FM(xm), xn=FN(xn) and cnt=cnt+1 each cycle; after DISCARD steps it SHALL clear cnt and go to FILL.
REQ-022 In FILL, the block SHALL write bufM[cnt]=xm and bufN[cnt]=xn, then step xm and xn; after writing cnt=LEN-1 it SHALL go to DONE.
REQ-023 Word 0 SHALL be the state after DISCARD steps; with DISCARD=0, word 0 SHALL equal the seed.
REQ-024 In DONE, the block SHALL assert done=1 for one cycle, set valid=1 and return to IDLE.
REQ-025 busy SHALL be 1 in BURN and FILL and 0 otherwise.
REQ-026 Latency: for start sampled at edge 0, done SHALL be high in the cycle after edge DISCARD+LEN+1.
REQ-027 start SHALL be ignored while not in IDLE; start in the DONE cycle SHALL be ignored.
REQ-028 Seed and parameter input changes after the start edge SHALL have no effect on the running generation.
REQ-029 Reads SHALL be synchronous: m_rd and n_rd SHALL show bufM[rd_addr] and bufN[rd_addr] one cycle after rd_addr is sampled, in all states.
REQ-030 During FILL, a read SHALL return the previous contents for any address not yet rewritten.
REQ-031 A zero seed stays zero under FM and FN; this SHALL NOT be flagged or altered.

Reset
REQ-032 While rst=1 at an edge, the block SHALL force IDLE, cnt=0, busy=0, done=0, valid=0, m_rd=0 and n_rd=0.
REQ-033 Buffer contents SHALL NOT be cleared by reset.
REQ-034 Reset mid-BURN or mid-FILL SHALL abort generation and leave valid=0 until the next completed run.
REQ-035 If rst and start are both 1 at the same edge, reset SHALL win.

Verification
REQ-036 W=16, LEN=8, DISCARD=0, m=0x1234, r1=r2=0 -> M words = 0x1234 followed by seven 0x0000; done 9 cycles after start; valid=1.
REQ-037 W=16, DISCARD=0, r1=0, r2=0x2000 (tent slope 1.0), m=0x1000 -> every M word = 0x1000.
REQ-038 LEN=8, DISCARD=4, any seeds -> busy high for 12 cycles; done 13 cycles after start; a second start during busy is ignored, with exactly one done pulse.
REQ-039 A random bench (W=32, LEN=256, DISCARD=16) SHALL compare all 512 words against a bit-exact reference model of REQ-013 to REQ-017.
REQ-040 Reset asserted at FILL cnt=3 -> busy=0 and valid=0 next cycle; a new start then completes normally with done=1.
REQ-041 m=n=0, r1=r2=0xFFFF, W=16 -> all words 0x0000; valid=1.
